// File: rtl/mollusc_pkg.sv
// rtl/mollusc_pkg.sv - shared widths, fetch entry type and PC helpers for the fetch stage
package mollusc_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 27;
  localparam int PRED_W  = 5;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [PRED_W-1:0]  pred;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic               fault;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory request/response, redirect and decode handshake bundle
interface fetch_unit_if;
  import mollusc_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_resp_valid;
  logic [XLEN-1:0]    imem_resp_data;
  logic               imem_resp_err;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PRED_W-1:0]  out_pred;
  logic [XLEN-1:0]    out_pc;
  logic               out_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pred, out_pc, out_fault,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pred, out_pc, out_fault,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous response buffer of fetch entries with flush
module fetch_fifo
  import mollusc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  // A pop frees the slot in the same edge, so push is allowed while full.
  assign do_push = push & ((count != FULL) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, credit-limited request issue, squash and halt control
module fetch_unit
  import mollusc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [XLEN-1:0] hold_addr_q;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   outstanding_n;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   fifo_count;
  logic            halted_q;
  logic            hold_q;
  logic            stale_q;
  logic            credit_ok;
  logic            req_valid;
  logic            hs;
  logic            resp_take;
  logic            push;
  logic            pop;
  logic            head_valid;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redirect_target = word_align(bus.redirect_pc);
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < CREDITS;
  assign req_valid = rst_n & (hold_q | (credit_ok & ~halted_q & ~bus.redirect_valid));
  assign hs        = req_valid & bus.imem_req_ready;
  // A response with nothing outstanding can only be a leftover from before reset.
  assign resp_take = bus.imem_resp_valid & (outstanding_q != '0);
  assign push      = resp_take & (drop_q == '0) & ~bus.redirect_valid;
  assign pop       = head_valid & bus.out_ready & ~bus.redirect_valid;
  assign outstanding_n = outstanding_q + CW'(hs) - CW'(resp_take);

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = resp_pc_q;
    push_entry.fault = bus.imem_resp_err;
    if (!bus.imem_resp_err) begin
      push_entry.pred  = bus.imem_resp_data[31:27];
      push_entry.instr = bus.imem_resp_data[26:0];
    end
  end

  // stale_q marks a held request raised before a redirect: it still completes, but is
  // squashed and must not advance the PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      hold_addr_q   <= RESET_PC;
      hold_q        <= 1'b0;
      stale_q       <= 1'b0;
      outstanding_q <= '0;
      drop_q        <= '0;
      halted_q      <= 1'b0;
    end else begin
      hold_q        <= req_valid & ~bus.imem_req_ready;
      hold_addr_q   <= bus.imem_req_addr;
      stale_q       <= req_valid & ~bus.imem_req_ready & (stale_q | bus.redirect_valid);
      outstanding_q <= outstanding_n;
      if (bus.redirect_valid) begin
        pc_q      <= redirect_target;
        resp_pc_q <= redirect_target;
        halted_q  <= 1'b0;
        drop_q    <= outstanding_n;
      end else begin
        if (hs && !stale_q)                pc_q      <= pc_q + PC_STEP;
        if (push)                          resp_pc_q <= resp_pc_q + PC_STEP;
        if (push && bus.imem_resp_err)     halted_q  <= 1'b1;
        drop_q <= drop_q - CW'(resp_take && (drop_q != '0)) + CW'(hs && stale_q);
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (push_entry),
    .head  (head),
    .valid (head_valid),
    .count (fifo_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = hold_q ? hold_addr_q : pc_q;
  assign bus.out_valid      = head_valid;
  assign bus.out_instr      = head.instr;
  assign bus.out_pred       = head.pred;
  assign bus.out_pc         = head.pc;
  assign bus.out_fault      = head_valid & head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector and sequence bench for fetch_unit
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int resp_lat = 1;
  int hs_count = 0;
  int cyc = 0;
  logic err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  typedef struct {
    logic        in_mem_ready;
    logic        in_out_ready;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
    logic [4:0]  exp_pred;
    logic [26:0] exp_instr;
  } vec_t;
  vec_t vecs[6];

  logic [31:0] drain_pc[4];
  logic        drain_rv[4];
  logic [31:0] drain_addr[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hF800_0123 ^ {a[23:0], 8'h00};
  endfunction

  // Instruction memory: in-order responses resp_lat cycles after acceptance.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (!rst_n) begin
      pend.delete();
    end else if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend.push_back('{bus.imem_req_addr, cyc + resp_lat - 1});
      hs_count = hs_count + 1;
    end
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(pend[0].addr);
      bus.imem_resp_err   = err_en && (pend[0].addr == err_addr);
      void'(pend.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.imem_resp_err   = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && (dut.outstanding_q > 3'd4 || dut.drop_q > 3'd4 || dut.fifo_count > 3'd4)) begin
      errors = errors + 1;
      $display("FAIL counter_bound: outstanding=%0d drop=%0d fifo_count=%0d limit=4",
               dut.outstanding_q, dut.drop_q, dut.fifo_count);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    err_en   = 1'b0;
    resp_lat = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    hs_count = 0;
  endtask

  task automatic wait_hs(input int n);
    int k;
    k = 0;
    while (hs_count < n && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("hs_reached", hs_count, n);
  endtask

  task automatic wait_out(input string name, input logic [31:0] epc, input logic [4:0] epred,
                          input logic [26:0] einstr, input logic efault);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 40);
    checks = checks + 1;
    if (!bus.out_valid) begin
      errors = errors + 1;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, expected an entry", name, k);
    end else if (bus.out_pc !== epc || bus.out_pred !== epred || bus.out_instr !== einstr ||
                 bus.out_fault !== efault) begin
      errors = errors + 1;
      $display("FAIL %s: got pc=0x%0h pred=0x%0h instr=0x%0h fault=%0b, expected pc=0x%0h pred=0x%0h instr=0x%0h fault=%0b",
               name, bus.out_pc, bus.out_pred, bus.out_instr, bus.out_fault, epc, epred, einstr, efault);
    end
  endtask

  initial begin
    int quiet;
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 5'h00, 27'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 5'h00, 27'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 5'h1F, 27'h000_0123};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 5'h1F, 27'h000_0523};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 5'h1F, 27'h000_0923};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 5'h1F, 27'h000_0D23};
    drain_pc   = '{32'h0, 32'h4, 32'h8, 32'hC};
    drain_rv   = '{1'b0, 1'b1, 1'b1, 1'b1};
    drain_addr = '{32'h0, 32'h10, 32'h14, 32'h18};

    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b1;
    bus.out_ready       = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("reset_req_valid", bus.imem_req_valid, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_fault", bus.out_fault, 0);

    // Streaming vectors
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.imem_req_ready = vecs[i].in_mem_ready;
      bus.out_ready      = vecs[i].in_out_ready;
      @(negedge clk);
      check($sformatf("v%0d_req_valid", i), bus.imem_req_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv) check($sformatf("v%0d_req_addr", i), bus.imem_req_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_out_valid", i), bus.out_valid, vecs[i].exp_ov);
      if (vecs[i].exp_ov) begin
        check($sformatf("v%0d_out_pc", i), bus.out_pc, vecs[i].exp_pc);
        check($sformatf("v%0d_out_pred", i), bus.out_pred, vecs[i].exp_pred);
        check($sformatf("v%0d_out_instr", i), bus.out_instr, vecs[i].exp_instr);
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: credits cap at four, then one new request per pop
    do_reset();
    bus.out_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("bp_requests", hs_count, 4);
    @(negedge clk);
    check("bp_req_valid_low", bus.imem_req_valid, 0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_fifo_full", dut.fifo_count, 4);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      check($sformatf("drain%0d_pc", d), bus.out_pc, drain_pc[d]);
      check($sformatf("drain%0d_req_valid", d), bus.imem_req_valid, drain_rv[d]);
      if (drain_rv[d]) check($sformatf("drain%0d_req_addr", d), bus.imem_req_addr, drain_addr[d]);
      @(posedge clk);
      #1;
    end

    // Redirect with three requests in flight
    do_reset();
    resp_lat = 5;
    wait_hs(3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1003;
    @(negedge clk);
    check("redir_no_req", bus.imem_req_valid, 0);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_req_valid", bus.imem_req_valid, 1);
    check("redir_req_addr", bus.imem_req_addr, 32'h1000);
    wait_out("redir_first_out", 32'h1000, 5'h1F, 27'h010_0123, 1'b0);

    // Redirect while a request is held by a stalled memory
    do_reset();
    wait_hs(2);
    bus.imem_req_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    check("hold_valid_t", bus.imem_req_valid, 1);
    check("hold_addr_t", bus.imem_req_addr, 32'h8);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("hold_addr_t1", bus.imem_req_addr, 32'h8);
    @(posedge clk);
    #1;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    check("hold_addr_accept", bus.imem_req_addr, 32'h8);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_next_valid", bus.imem_req_valid, 1);
    check("hold_next_addr", bus.imem_req_addr, 32'h40);
    wait_out("hold_first_out", 32'h40, 5'h1F, 27'h000_4123, 1'b0);

    // Bus fault halts issue until a redirect
    do_reset();
    err_en   = 1'b1;
    err_addr = 32'h4;
    wait_out("fault_e0", 32'h0, 5'h1F, 27'h000_0123, 1'b0);
    wait_out("fault_e1", 32'h4, 5'h00, 27'h0, 1'b1);
    wait_out("fault_e2", 32'h8, 5'h1F, 27'h000_0923, 1'b0);
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.imem_req_valid) quiet++;
    end
    check("fault_halted_reqs", quiet, 0);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    check("fault_redir_no_req", bus.imem_req_valid, 0);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("fault_resume_valid", bus.imem_req_valid, 1);
    check("fault_resume_addr", bus.imem_req_addr, 32'h200);
    wait_out("fault_resume_out", 32'h200, 5'h1F, 27'h002_0123, 1'b0);

    // One-cycle reset with two responses outstanding
    do_reset();
    resp_lat = 4;
    wait_hs(2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req_valid", bus.imem_req_valid, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    hs_count = 0;
    @(negedge clk);
    check("midrst_first_valid", bus.imem_req_valid, 1);
    check("midrst_first_addr", bus.imem_req_addr, 32'h0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_fault", bus.out_fault, 0);
    wait_out("midrst_out0", 32'h0, 5'h1F, 27'h000_0123, 1'b0);
    wait_out("midrst_out1", 32'h4, 5'h1F, 27'h000_0523, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
